// File: rtl/rgb_frame_reader_pkg.sv
// Shared frame constants and reader state encoding for the RGB frame reader.
// The frame constants match the layout the colourspace stage writes to SRAM.
package rgb_frame_reader_pkg;

  localparam logic [17:0] RGB_BASE   = 18'd146944;
  localparam int          IMG_WIDTH  = 320;
  localparam int          IMG_HEIGHT = 240;
  localparam int          SRAM_LAT   = 2;

  typedef enum logic [3:0] {
    S_RF_IDLE,
    S_RF_RD0,
    S_RF_RD1,
    S_RF_RD2,
    S_RF_CAP1,
    S_RF_CAP2,
    S_RF_EMIT0,
    S_RF_EMIT1,
    S_RF_FIN
  } rf_state_type;

endpackage

// File: rtl/rgb_frame_reader_pair_unpack.sv
// Byte router: three packed SRAM words carry one even/odd pixel pair.
// W0={R_even,G_even}, W1={B_even,R_odd}, W2={G_odd,B_odd}; outputs are {R,G,B}.
module rgb_pair_unpack (
  input  logic [15:0] w0,
  input  logic [15:0] w1,
  input  logic [15:0] w2,
  output logic [23:0] even_rgb,
  output logic [23:0] odd_rgb
);

  assign even_rgb = {w0[15:8], w0[7:0], w1[15:8]};
  assign odd_rgb  = {w1[7:0], w2[15:8], w2[7:0]};

endmodule

// File: rtl/rgb_frame_reader.sv
// Reads the packed RGB frame from SRAM and streams one 24-bit pixel per
// handshake, flagging end-of-line and end-of-frame on the qualifying pixel.
module rgb_frame_reader #(
  parameter logic [17:0] RGB_BASE   = rgb_frame_reader_pkg::RGB_BASE,
  parameter int          IMG_WIDTH  = rgb_frame_reader_pkg::IMG_WIDTH,
  parameter int          IMG_HEIGHT = rgb_frame_reader_pkg::IMG_HEIGHT
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic [17:0] SRAM_address,
  input  logic [15:0] SRAM_read_data,
  output logic        SRAM_we_n,
  output logic [7:0]  pix_R,
  output logic [7:0]  pix_G,
  output logic [7:0]  pix_B,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_eol,
  output logic        pix_eof,
  output logic [3:0]  debug_state
);
  import rgb_frame_reader_pkg::*;

  localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

  rf_state_type state, state_n;
  logic [18:0]  word_addr;
  logic [18:0]  rd_addr;
  logic [15:0]  w0, w1, w2;
  logic [15:0]  x, y;
  logic [23:0]  even_rgb, odd_rgb;
  logic         hs, at_eol, at_eof;
  logic         unused_addr_carry;

  // Pixel handshake: a pixel transfers on a cycle with pix_valid && pix_ready;
  // while pix_valid is high and pix_ready low every pix_* output holds, and
  // pix_valid only falls after a transfer.
  assign hs     = pix_valid && pix_ready;
  assign at_eol = (x == X_LAST);
  assign at_eof = at_eol && (y == Y_LAST);

  rgb_pair_unpack u_unpack (
    .w0       (w0),
    .w1       (w1),
    .w2       (w2),
    .even_rgb (even_rgb),
    .odd_rgb  (odd_rgb)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= S_RF_IDLE;
      word_addr <= {1'b0, RGB_BASE};
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      x         <= '0;
      y         <= '0;
    end else begin
      state <= state_n;
      case (state)
        S_RF_IDLE: begin
          if (Start) begin
            word_addr <= {1'b0, RGB_BASE};
            x         <= '0;
            y         <= '0;
          end
        end
        S_RF_RD2:  w0 <= SRAM_read_data;
        S_RF_CAP1: w1 <= SRAM_read_data;
        S_RF_CAP2: begin
          w2        <= SRAM_read_data;
          word_addr <= word_addr + 19'd3;
        end
        S_RF_EMIT0: if (hs) x <= x + 16'd1;
        S_RF_EMIT1: begin
          if (hs) begin
            if (at_eol) begin
              x <= '0;
              y <= at_eof ? 16'd0 : y + 16'd1;
            end else begin
              x <= x + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n   = state;
    rd_addr   = {1'b0, RGB_BASE};
    Busy      = 1'b1;
    Done      = 1'b0;
    pix_valid = 1'b0;
    pix_eol   = 1'b0;
    pix_eof   = 1'b0;
    {pix_R, pix_G, pix_B} = 24'd0;
    case (state)
      S_RF_IDLE: begin
        Busy = 1'b0;
        if (Start) state_n = S_RF_RD0;
      end
      S_RF_RD0: begin
        rd_addr = word_addr;
        state_n = S_RF_RD1;
      end
      S_RF_RD1: begin
        rd_addr = word_addr + 19'd1;
        state_n = S_RF_RD2;
      end
      S_RF_RD2: begin
        rd_addr = word_addr + 19'd2;
        state_n = S_RF_CAP1;
      end
      S_RF_CAP1: state_n = S_RF_CAP2;
      S_RF_CAP2: state_n = S_RF_EMIT0;
      S_RF_EMIT0: begin
        pix_valid = 1'b1;
        {pix_R, pix_G, pix_B} = even_rgb;
        if (pix_ready) state_n = S_RF_EMIT1;
      end
      S_RF_EMIT1: begin
        pix_valid = 1'b1;
        pix_eol   = at_eol;
        pix_eof   = at_eof;
        {pix_R, pix_G, pix_B} = odd_rgb;
        if (pix_ready) state_n = at_eof ? S_RF_FIN : S_RF_RD0;
      end
      S_RF_FIN: begin
        Busy    = 1'b0;
        Done    = 1'b1;
        state_n = S_RF_IDLE;
      end
      default: begin
        Busy    = 1'b0;
        state_n = S_RF_IDLE;
      end
    endcase
  end

  // Bit 18 only becomes set by the +3 after the final group, which is never issued.
  assign unused_addr_carry = rd_addr[18];
  assign SRAM_address      = rd_addr[17:0];
  assign SRAM_we_n         = 1'b1;
  assign debug_state       = state;

endmodule

// File: doc/rgb_frame_reader.md
Name: rgb_frame_reader

Overview:
- Downstream neighbour of the YUV-to-RGB colourspace stage.
- Reads the packed RGB frame that the colourspace stage wrote to external SRAM starting at word 146944, unpacks it, and streams one 24-bit pixel per handshake to the display/pixel sink.
- Packing is 3 SRAM words per even/odd pixel pair: W0={R_even,G_even}, W1={B_even,R_odd}, W2={G_odd,B_odd}. First-named byte is in [15:8].
- Owns the SRAM port only while busy; never writes.

Parameters:
- RGB_BASE, 18'd146944, word address of W0 of pixel 0.
- IMG_WIDTH, 320, pixels per line; must be even.
- IMG_HEIGHT, 240, lines per frame.
- SRAM_LAT, 2, cycles from address presented to SRAM_read_data valid.

Ports:
- Clock  in  1  single clock.
- Reset  in  1  synchronous, active-high.
- Start  in  1  one-cycle pulse; begins a frame when idle.
- Busy  out  1  high from the cycle after an accepted Start until Done.
- Done  out  1  one-cycle pulse after the last pixel handshake.
- SRAM_address  out  18  read address.
- SRAM_read_data  in  16  read data, SRAM_LAT cycles after its address.
- SRAM_we_n  out  1  held 1 at all times.
- pix_R, pix_G, pix_B  out  8 each  pixel components.
- pix_valid  out  1  pixel on pix_* is valid.
- pix_ready  in  1  sink accepts the pixel when valid&&ready.
- pix_eol  out  1  qualifies the last pixel of a line (x==IMG_WIDTH-1).
- pix_eof  out  1  qualifies the last pixel of the frame.

Behaviour:
- Reset (synchronous, any state, including mid-frame):
  - state=S_RF_IDLE; all counters 0; SRAM_address=RGB_BASE; SRAM_we_n=1.
  - Busy=0, Done=0, pix_valid=0, pix_eol=0, pix_eof=0, pix_R/G/B=0.
  - No residual pixel is emitted after reset.
- Handshake:
  - pix_* and pix_eol/pix_eof hold stable while pix_valid=1 && pix_ready=0.
  - pix_valid never drops without a handshake.
- FSM states:
  - S_RF_IDLE: on Start → S_RF_RD0, Busy=1, word_addr=RGB_BASE. Start in any other state is ignored.
  - S_RF_RD0: SRAM_address=word_addr.
  - S_RF_RD1: SRAM_address=word_addr+1.
  - S_RF_RD2: SRAM_address=word_addr+2; capture W0 (data from the RD0 address).
  - S_RF_CAP1: capture W1.
  - S_RF_CAP2: capture W2; word_addr+=3.
  - S_RF_EMIT0: pix_valid=1 with {R_even,G_even,B_even}; stay until handshake.
  - S_RF_EMIT1: {R_odd,G_odd,B_odd}; on handshake → S_RF_RD0 if pixels remain, else S_RF_FIN.
  - S_RF_FIN: Done=1 for 1 cycle, Busy=0 → S_RF_IDLE.
- Latency:
  - First pix_valid is 6 cycles after the Start cycle.
  - Sustained throughput with pix_ready tied high is 2 pixels per 7 cycles.
- Counters:
  - x 0..IMG_WIDTH-1, wraps to 0 and increments y on an eol handshake.
  - y 0..IMG_HEIGHT-1.
  - pix_eof = (x==IMG_WIDTH-1 && y==IMG_HEIGHT-1).
  - eol/eof are only asserted in S_RF_EMIT1, because IMG_WIDTH is even.
- Address width:
  - Last word is RGB_BASE + IMG_WIDTH*IMG_HEIGHT*3/2 - 1 = 262143 (18'h3FFFF) at defaults.
  - Compute word_addr as 19 bits internally; the +3 after the final group wraps to 0 in 18 bits and is never issued.
- Byte unpack (no arithmetic, no clipping; values were already clipped upstream):
  - R_even=W0[15:8], G_even=W0[7:0], B_even=W1[15:8].
  - R_odd=W1[7:0], G_odd=W2[15:8], B_odd=W2[7:0].
- Simultaneous events: Reset dominates Start and pix_ready. A Start in the same cycle as Done is ignored.

Decomposition:
- Shared state package (alongside the existing state typedefs):
  - enum rf_state_type {S_RF_IDLE, S_RF_RD0, S_RF_RD1, S_RF_RD2, S_RF_CAP1, S_RF_CAP2, S_RF_EMIT0, S_RF_EMIT1, S_RF_FIN}.
  - Frame constants RGB_BASE, IMG_WIDTH, IMG_HEIGHT, shared with the colourspace stage.
- One natural sub-module: rgb_pair_unpack, a combinational 3×16-bit → 2×24-bit byte router, reused by the bench's scoreboard.
- FSM, address and x/y counters live in the top module.

Test Plan:
- Single group, ready high:
  - Stimulus: SRAM model with W0=16'h1122, W1=16'h3344, W2=16'h5566 at 146944..146946.
  - Required: pixel0=(11,22,33), pixel1=(44,55,66). First valid 6 cycles after Start. SRAM_we_n=1 throughout.
- Full frame, ready high:
  - Stimulus: SRAM preloaded with the known pattern.
  - Required: exactly 76800 handshakes. pix_eol on pixel 319 of every line (240 total). pix_eof only on pixel 76799. Last address issued is 18'h3FFFF. Done 1 cycle after the final handshake. Busy low afterwards.
- Backpressure:
  - Stimulus: pix_ready toggled randomly (incl. held low 20 cycles in S_RF_EMIT1).
  - Required: pix_* stable while stalled, no pixel lost or duplicated, scoreboard matches.
- Reset mid-frame:
  - Stimulus: assert Reset at pixel 1000 with pix_valid=1.
  - Required: next cycle pix_valid=0, Busy=0, SRAM_address=146944. A subsequent Start re-reads from pixel 0.
- Start ignored:
  - Stimulus: extra Start pulses while Busy, and a Start coincident with Done.
  - Required: pixel count stays 76800 and no second frame begins.
